// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared constants, opcodes, FSM states and instruction fields for the ALU issue block
package alu_pkg;

  localparam int BITS    = 8;
  localparam int ALUOP   = 4;
  localparam int REGS    = 8;
  localparam int RADDR_W = 3;
  localparam int INSTR_W = 16;

  // Instruction field offsets (LSB of each field)
  localparam int OP_LSB  = 12;
  localparam int RD_LSB  = 9;
  localparam int RA_LSB  = 6;
  localparam int RB_LSB  = 3;
  localparam int IMM_LSB = 0;

  // Opcodes; 0 and 12-15 are illegal
  localparam logic [ALUOP-1:0] OP_ADD  = 4'd1;
  localparam logic [ALUOP-1:0] OP_SUB  = 4'd2;
  localparam logic [ALUOP-1:0] OP_AND  = 4'd3;
  localparam logic [ALUOP-1:0] OP_OR   = 4'd4;
  localparam logic [ALUOP-1:0] OP_XOR  = 4'd5;
  localparam logic [ALUOP-1:0] OP_MOVS = 4'd6;
  localparam logic [ALUOP-1:0] OP_MOVR = 4'd7;
  localparam logic [ALUOP-1:0] OP_SHL  = 4'd8;
  localparam logic [ALUOP-1:0] OP_SHR  = 4'd9;
  localparam logic [ALUOP-1:0] OP_ROTR = 4'd10;
  localparam logic [ALUOP-1:0] OP_ROTL = 4'd11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    EXEC = 2'd2,
    WB   = 2'd3
  } state_t;

  function automatic logic op_is_legal(input logic [ALUOP-1:0] op);
    return (op >= OP_ADD) && (op <= OP_ROTL);
  endfunction

endpackage

// File: rtl/alu_regfile.sv
// rtl/alu_regfile.sv - 8-entry register file, two async read ports, debug port, one sync write
module alu_regfile
  import alu_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_we,
  input  logic [RADDR_W-1:0] i_waddr,
  input  logic [BITS-1:0]    i_wdata,
  input  logic [RADDR_W-1:0] i_raddr_a,
  input  logic [RADDR_W-1:0] i_raddr_b,
  input  logic [RADDR_W-1:0] i_dbg_addr,
  output logic [BITS-1:0]    o_rdata_a,
  output logic [BITS-1:0]    o_rdata_b,
  output logic [BITS-1:0]    o_dbg_data
);

  logic [BITS-1:0] r_mem [REGS];

  // Storage: cleared asynchronously, one write per clock
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < REGS; i++) r_mem[i] <= '0;
    end else if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata_a  = r_mem[i_raddr_a];
  assign o_rdata_b  = r_mem[i_raddr_b];
  assign o_dbg_data = r_mem[i_dbg_addr];

endmodule

// File: rtl/alu_issue_ctrl.sv
// rtl/alu_issue_ctrl.sv - issue side of the 8-bit ALU: decode, operand read, execute, writeback
module alu_issue_ctrl
  import alu_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic [INSTR_W-1:0] instr,
  input  logic               instrValid,
  output logic               instrReady,
  output logic [ALUOP-1:0]   aluFunction,
  output logic [BITS-1:0]    vectorA,
  output logic [BITS-1:0]    vectorB,
  input  logic [BITS-1:0]    aluResult,
  output logic               done,
  output logic               zero,
  output logic               errFlag,
  input  logic [2:0]         dbgAddr,
  output logic [BITS-1:0]    dbgData
);

  state_t             r_state;
  state_t             w_next;
  logic [INSTR_W-1:0] r_instr;
  logic [BITS-1:0]    r_res;

  logic [ALUOP-1:0]   w_op;
  logic [RADDR_W-1:0] w_rd;
  logic [RADDR_W-1:0] w_ra;
  logic [RADDR_W-1:0] w_rb;
  logic [BITS-1:0]    w_imm;
  logic [BITS-1:0]    w_rdata_a;
  logic [BITS-1:0]    w_rdata_b;
  logic               w_legal;
  logic               w_rot;

  assign w_op    = r_instr[OP_LSB +: ALUOP];
  assign w_rd    = r_instr[RD_LSB +: RADDR_W];
  assign w_ra    = r_instr[RA_LSB +: RADDR_W];
  assign w_rb    = r_instr[RB_LSB +: RADDR_W];
  assign w_imm   = r_instr[IMM_LSB +: BITS];
  assign w_legal = op_is_legal(w_op);
  assign w_rot   = (w_op == OP_ROTR) || (w_op == OP_ROTL);

  alu_regfile u_regfile (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_we       (r_state == WB),
    .i_waddr    (w_rd),
    .i_wdata    (r_res),
    .i_raddr_a  (w_ra),
    .i_raddr_b  (w_rb),
    .i_dbg_addr (dbgAddr),
    .o_rdata_a  (w_rdata_a),
    .o_rdata_b  (w_rdata_b),
    .o_dbg_data (dbgData)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  // Next state plus the decoded handshake/retire outputs
  always_comb begin
    w_next     = r_state;
    instrReady = 1'b0;
    done       = 1'b0;
    unique case (r_state)
      IDLE: begin
        instrReady = 1'b1;
        if (instrValid) w_next = READ;
      end
      READ:    w_next = w_legal ? EXEC : IDLE;
      EXEC:    w_next = WB;
      WB: begin
        done   = 1'b1;
        w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // Latch the instruction on the accept edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                            r_instr <= '0;
    else if (r_state == IDLE && instrValid) r_instr <= instr;
  end

  // ALU drive: loaded leaving READ, cleared otherwise so the ALU only sees a live op in EXEC
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      aluFunction <= '0;
      vectorA     <= '0;
      vectorB     <= '0;
    end else if (r_state == READ && w_legal) begin
      aluFunction <= w_op;
      vectorA     <= w_rdata_a;
      vectorB     <= w_rot ? {{(BITS-3){1'b0}}, w_rdata_b[2:0]} : w_rdata_b;
    end else begin
      aluFunction <= '0;
      vectorA     <= '0;
      vectorB     <= '0;
    end
  end

  // Capture the result at the end of EXEC; the two moves bypass the ALU
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_res <= '0;
    end else if (r_state == EXEC) begin
      if (w_op == OP_MOVS)      r_res <= w_imm;
      else if (w_op == OP_MOVR) r_res <= vectorA;
      else                      r_res <= aluResult;
    end
  end

  // Status flags: zero follows each writeback, errFlag is sticky until reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      zero    <= 1'b0;
      errFlag <= 1'b0;
    end else begin
      if (r_state == WB)               zero    <= (r_res == '0);
      if (r_state == READ && !w_legal) errFlag <= 1'b1;
    end
  end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb/tb_alu_issue_ctrl.sv - self-checking bench for alu_issue_ctrl with a behavioural ALU
module tb_alu_issue_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] instr = '0;
  logic        instrValid = 1'b0;
  logic        instrReady;
  logic [3:0]  aluFunction;
  logic [7:0]  vectorA;
  logic [7:0]  vectorB;
  logic [7:0]  aluResult;
  logic        done;
  logic        zero;
  logic        errFlag;
  logic [2:0]  dbgAddr = '0;
  logic [7:0]  dbgData;

  int n_pass  = 0;
  int n_total = 0;

  logic [7:0] shadow [8];
  logic [3:0] cap_fn;
  logic [7:0] cap_va;
  logic [7:0] cap_vb;

  always #5 clk = ~clk;

  alu_issue_ctrl dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .instr       (instr),
    .instrValid  (instrValid),
    .instrReady  (instrReady),
    .aluFunction (aluFunction),
    .vectorA     (vectorA),
    .vectorB     (vectorB),
    .aluResult   (aluResult),
    .done        (done),
    .zero        (zero),
    .errFlag     (errFlag),
    .dbgAddr     (dbgAddr),
    .dbgData     (dbgData)
  );

  // Behavioural combinational ALU
  logic [15:0] dbl;
  logic [15:0] rl;
  always_comb begin
    dbl       = {vectorA, vectorA};
    rl        = dbl << vectorB[2:0];
    aluResult = 8'h00;
    case (aluFunction)
      4'd1:    aluResult = vectorA + vectorB;
      4'd2:    aluResult = vectorA - vectorB;
      4'd3:    aluResult = vectorA & vectorB;
      4'd4:    aluResult = vectorA | vectorB;
      4'd5:    aluResult = vectorA ^ vectorB;
      4'd8:    aluResult = vectorA << vectorB[2:0];
      4'd9:    aluResult = vectorA >> vectorB[2:0];
      4'd10:   aluResult = 8'(dbl >> vectorB[2:0]);
      4'd11:   aluResult = rl[15:8];
      default: aluResult = 8'h00;
    endcase
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    else             n_pass++;
  endtask

  function automatic logic [15:0] mk(input logic [3:0] op, input logic [2:0] rd,
                                     input logic [2:0] ra, input logic [2:0] rb);
    return {op, rd, ra, rb, 3'b000};
  endfunction

  function automatic logic [15:0] mki(input logic [3:0] op, input logic [2:0] rd,
                                      input logic [7:0] imm);
    return {op, rd, 1'b0, imm};
  endfunction

  // Wait (bounded) for instrReady, present one instruction and release valid after the accept edge
  task automatic accept_instr(input logic [15:0] ins);
    int w = 0;
    @(negedge clk);
    while (!instrReady && w < 20) begin
      @(negedge clk);
      w++;
    end
    if (!instrReady) chk("ready_timeout", 0, 1);
    instr      = ins;
    instrValid = 1'b1;
    @(posedge clk);
    #1 instrValid = 1'b0;
  endtask

  // Cycles from accept to done; ALU drive captured in cycle 2
  task automatic wait_done(output int lat);
    lat = -1;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      if (c == 2) begin
        cap_fn = aluFunction;
        cap_va = vectorA;
        cap_vb = vectorB;
      end
      if (done) begin
        lat = c;
        break;
      end
    end
  endtask

  task automatic chk_regs(input string name);
    for (int r = 0; r < 8; r++) begin
      dbgAddr = 3'(r);
      #1 chk($sformatf("%s_R%0d", name, r), {24'd0, dbgData}, {24'd0, shadow[r]});
    end
  endtask

  typedef struct {
    string       name;
    logic [15:0] ins;
    logic [2:0]  rd;
    logic [7:0]  exp_val;
    logic        exp_z;
  } vec_t;

  vec_t vecs [16];

  initial begin
    int lat;
    int nd;

    vecs[0]  = '{"movs_r1",   mki(4'd6, 3'd1, 8'h05),       3'd1, 8'h05, 1'b0};
    vecs[1]  = '{"movs_r2",   mki(4'd6, 3'd2, 8'h03),       3'd2, 8'h03, 1'b0};
    vecs[2]  = '{"add_r3",    mk(4'd1, 3'd3, 3'd1, 3'd2),   3'd3, 8'h08, 1'b0};
    vecs[3]  = '{"sub_r4",    mk(4'd2, 3'd4, 3'd2, 3'd2),   3'd4, 8'h00, 1'b1};
    vecs[4]  = '{"movs_r6",   mki(4'd6, 3'd6, 8'hFF),       3'd6, 8'hFF, 1'b0};
    vecs[5]  = '{"movs_r7",   mki(4'd6, 3'd7, 8'h01),       3'd7, 8'h01, 1'b0};
    vecs[6]  = '{"add_wrap",  mk(4'd1, 3'd0, 3'd6, 3'd7),   3'd0, 8'h00, 1'b1};
    vecs[7]  = '{"movs_r1b",  mki(4'd6, 3'd1, 8'h81),       3'd1, 8'h81, 1'b0};
    vecs[8]  = '{"movs_r5",   mki(4'd6, 3'd5, 8'h09),       3'd5, 8'h09, 1'b0};
    vecs[9]  = '{"rotr_r3",   mk(4'd10, 3'd3, 3'd1, 3'd5),  3'd3, 8'hC0, 1'b0};
    vecs[10] = '{"movr_r2",   mk(4'd7, 3'd2, 3'd1, 3'd0),   3'd2, 8'h81, 1'b0};
    vecs[11] = '{"xor_r4",    mk(4'd5, 3'd4, 3'd1, 3'd5),   3'd4, 8'h88, 1'b0};
    vecs[12] = '{"rotl_r6",   mk(4'd11, 3'd6, 3'd1, 3'd7),  3'd6, 8'h03, 1'b0};
    vecs[13] = '{"and_r0",    mk(4'd3, 3'd0, 3'd1, 3'd5),   3'd0, 8'h01, 1'b0};
    vecs[14] = '{"add_self",  mk(4'd1, 3'd5, 3'd5, 3'd5),   3'd5, 8'h12, 1'b0};
    vecs[15] = '{"movs_zero", mki(4'd6, 3'd7, 8'h00),       3'd7, 8'h00, 1'b1};
    for (int r = 0; r < 8; r++) shadow[r] = 8'h00;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_ready", {31'd0, instrReady}, 1);
    chk("rst_done", {31'd0, done}, 0);
    chk("rst_zero", {31'd0, zero}, 0);
    chk("rst_err", {31'd0, errFlag}, 0);
    chk("rst_fn", {28'd0, aluFunction}, 0);
    chk("rst_va", {24'd0, vectorA}, 0);
    chk("rst_vb", {24'd0, vectorB}, 0);
    chk_regs("rst");
    rst_n = 1'b1;

    // Table-driven instruction sequence
    for (int i = 0; i < 16; i++) begin
      accept_instr(vecs[i].ins);
      wait_done(lat);
      chk({vecs[i].name, "_lat"}, 32'(lat), 3);
      chk({vecs[i].name, "_fn"}, {28'd0, cap_fn}, {28'd0, vecs[i].ins[15:12]});
      if (vecs[i].ins[15:12] == 4'd10) chk({vecs[i].name, "_vb"}, {24'd0, cap_vb}, 1);
      @(negedge clk);
      dbgAddr = vecs[i].rd;
      #1 chk({vecs[i].name, "_val"}, {24'd0, dbgData}, {24'd0, vecs[i].exp_val});
      chk({vecs[i].name, "_zero"}, {31'd0, zero}, {31'd0, vecs[i].exp_z});
      shadow[vecs[i].rd] = vecs[i].exp_val;
    end
    chk("idle_fn", {28'd0, aluFunction}, 0);
    chk_regs("seq");

    // Illegal opcode: error flag, no done, back to ready two cycles after accept
    accept_instr(mk(4'hE, 3'd3, 3'd1, 3'd2));
    @(negedge clk);
    chk("ill_c1_ready", {31'd0, instrReady}, 0);
    chk("ill_c1_fn", {28'd0, aluFunction}, 0);
    @(negedge clk);
    chk("ill_c2_ready", {31'd0, instrReady}, 1);
    chk("ill_c2_err", {31'd0, errFlag}, 1);
    chk("ill_c2_fn", {28'd0, aluFunction}, 0);
    nd = 0;
    for (int c = 0; c < 5; c++) begin
      if (done) nd++;
      @(negedge clk);
    end
    chk("ill_no_done", 32'(nd), 0);
    chk_regs("ill");

    // Continuous valid: one accept every 4 cycles
    @(negedge clk);
    instr      = mki(4'd6, 3'd1, 8'h11);
    instrValid = 1'b1;
    for (int k = 0; k < 16; k++) begin
      if (k > 0) @(negedge clk);
      chk($sformatf("hold_ready_%0d", k), {31'd0, instrReady}, {31'd0, (k % 4) == 0});
      chk($sformatf("hold_done_%0d", k), {31'd0, done}, {31'd0, (k % 4) == 3});
    end
    @(negedge clk);
    instrValid = 1'b0;
    shadow[1] = 8'h11;
    chk("hold_err_sticky", {31'd0, errFlag}, 1);
    chk_regs("hold");

    // Reset during EXEC aborts the instruction
    accept_instr(mk(4'd1, 3'd4, 3'd1, 3'd2));
    @(negedge clk);
    @(negedge clk);
    chk("abort_exec_fn", {28'd0, aluFunction}, 1);
    chk("abort_exec_va", {24'd0, vectorA}, 8'h11);
    rst_n = 1'b0;
    #1;
    chk("abort_fn", {28'd0, aluFunction}, 0);
    chk("abort_va", {24'd0, vectorA}, 0);
    chk("abort_vb", {24'd0, vectorB}, 0);
    chk("abort_ready", {31'd0, instrReady}, 1);
    chk("abort_done", {31'd0, done}, 0);
    chk("abort_err", {31'd0, errFlag}, 0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    nd = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (done) nd++;
    end
    chk("abort_no_done", 32'(nd), 0);
    for (int r = 0; r < 8; r++) shadow[r] = 8'h00;
    chk_regs("abort");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
